// File: rtl/ddr3_rd_sched_pkg.sv
// ddr3_rd_sched_pkg: shared ddr3 read-scheduler state encodings and beat-to-address step.
package ddr3_rd_sched_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CHK  = 2'd1;
    localparam logic [1:0] S_REQ  = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    // one beat spans eight DQ-wide words; at 16-bit DQ that is dq_width/2
    localparam int BEAT_WORD_DIV = 2;

    function automatic int addr_step(input int dq_width);
        return dq_width / BEAT_WORD_DIV;
    endfunction

endpackage

// File: rtl/ddr3_rd_credit.sv
// ddr3_rd_credit: downstream FIFO slot credit; +1 per pop, -amt per take, clamped at FIFO_DEPTH.
module ddr3_rd_credit #(
    parameter int CNT_W      = 20,
    parameter int FIFO_DEPTH = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pop,
    input  logic             take,
    input  logic [CNT_W:0]   amt,
    output logic [CNT_W:0]   credit
);
    localparam logic [CNT_W:0] FULL = (CNT_W+1)'(FIFO_DEPTH);

    logic [CNT_W+1:0] sum;

    // the scheduler only takes when credit covers amt, so sum never underflows
    assign sum = {1'b0, credit} + (CNT_W+2)'(pop) - (take ? {1'b0, amt} : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            credit <= FULL;
        else
            credit <= (sum > {1'b0, FULL}) ? FULL : sum[CNT_W:0];
    end

endmodule

// File: rtl/ddr3_rd_sched.sv
// ddr3_rd_sched: splits a frame read into credit-gated DDR3 bursts, one request outstanding.
module ddr3_rd_sched
    import ddr3_rd_sched_pkg::*;
#(
    parameter int         CTRL_ADDR_WIDTH = 28,
    parameter int         MEM_DQ_WIDTH    = 16,
    parameter int         BURST_LEN       = 16,
    parameter int         FIFO_DEPTH      = 512,
    parameter int         CNT_W           = 20,
    parameter logic [3:0] AXI_ID          = 4'd0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [CTRL_ADDR_WIDTH-1:0] frame_base,
    input  logic [CNT_W-1:0]           frame_beats,
    input  logic                       fifo_pop,
    output logic                       read_en,
    output logic [CTRL_ADDR_WIDTH-1:0] ddr3_rd_addr,
    output logic [3:0]                 ddr3_axi_id,
    output logic [3:0]                 ddr3_axi_len,
    output logic                       ddr3_axi_ap,
    input  logic                       read_done_p,
    input  logic                       ddr3_rd_valid,
    output logic                       busy,
    output logic                       frame_done
);
    localparam int ADDR_STEP = addr_step(MEM_DQ_WIDTH);

    logic [1:0]                 state;
    logic [CTRL_ADDR_WIDTH-1:0] addr_ptr;
    logic [CNT_W-1:0]           remain;
    logic [CNT_W-1:0]           beats_q;
    logic [CNT_W-1:0]           rx_cnt;
    logic [4:0]                 blen;
    logic [4:0]                 blen_q;
    logic [CNT_W:0]             credit;
    logic                       take;

    assign blen        = (remain >= CNT_W'(BURST_LEN)) ? 5'(BURST_LEN) : remain[4:0];
    assign take        = (state == S_REQ) && read_done_p;
    assign busy        = (state != S_IDLE);
    assign frame_done  = (state == S_WAIT) && (rx_cnt == beats_q);
    assign ddr3_axi_id = AXI_ID;
    assign ddr3_axi_ap = 1'b0;

    ddr3_rd_credit #(
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_credit (
        .clk    (clk),
        .rst_n  (rst_n),
        .pop    (fifo_pop),
        .take   (take),
        .amt    ((CNT_W+1)'(blen_q)),
        .credit (credit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            read_en      <= 1'b0;
            ddr3_rd_addr <= '0;
            ddr3_axi_len <= '0;
            addr_ptr     <= '0;
            remain       <= '0;
            beats_q      <= '0;
            rx_cnt       <= '0;
            blen_q       <= '0;
        end else begin
            if (state != S_IDLE && ddr3_rd_valid)
                rx_cnt <= rx_cnt + 1'b1;
            case (state)
                S_IDLE: if (start) begin
                    addr_ptr <= frame_base;
                    remain   <= frame_beats;
                    beats_q  <= frame_beats;
                    rx_cnt   <= '0;
                    state    <= S_CHK;
                end
                S_CHK: if (remain == '0) begin
                    state <= S_WAIT;
                end else if (credit >= (CNT_W+1)'(blen)) begin
                    read_en      <= 1'b1;
                    ddr3_rd_addr <= addr_ptr;
                    ddr3_axi_len <= 4'(blen - 5'd1);
                    blen_q       <= blen;
                    state        <= S_REQ;
                end
                S_REQ: if (read_done_p) begin
                    read_en  <= 1'b0;
                    remain   <= remain - CNT_W'(blen_q);
                    addr_ptr <= addr_ptr + CTRL_ADDR_WIDTH'(blen_q) * CTRL_ADDR_WIDTH'(ADDR_STEP);
                    state    <= S_CHK;
                end
                default: if (frame_done) state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_rd_sched.sv
// tb_ddr3_rd_sched: scoreboard bench with a modelled read controller and downstream FIFO.
module tb_ddr3_rd_sched;

    localparam int AW    = 28;
    localparam int CW    = 20;
    localparam int DEPTH = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    len;
    } req_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] frame_base = '0;
    logic [CW-1:0] frame_beats = '0;
    logic          fifo_pop;
    logic          read_en;
    logic [AW-1:0] ddr3_rd_addr;
    logic [3:0]    ddr3_axi_id;
    logic [3:0]    ddr3_axi_len;
    logic          ddr3_axi_ap;
    logic          read_done_p;
    logic          ddr3_rd_valid;
    logic          busy;
    logic          frame_done;

    req_t          exp_q[$];
    int            errors = 0;
    int            checks = 0;
    int            req_cnt = 0;
    int            done_cnt = 0;
    int            valid_total = 0;
    int            exp_beats = 0;
    int            pop_budget = 0;
    bit            pop_on_ack = 1'b0;
    int            ack_cnt = 0;
    int            pend = 0;
    int            fifo_lvl = 0;
    logic          re_q = 1'b0;
    logic [AW-1:0] hold_addr = '0;
    logic [3:0]    hold_len = '0;

    ddr3_rd_sched #(.FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .frame_base    (frame_base),
        .frame_beats   (frame_beats),
        .fifo_pop      (fifo_pop),
        .read_en       (read_en),
        .ddr3_rd_addr  (ddr3_rd_addr),
        .ddr3_axi_id   (ddr3_axi_id),
        .ddr3_axi_len  (ddr3_axi_len),
        .ddr3_axi_ap   (ddr3_axi_ap),
        .read_done_p   (read_done_p),
        .ddr3_rd_valid (ddr3_rd_valid),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    // read controller acks on the third cycle of read_en, then streams the beats into a FIFO model
    initial begin
        read_done_p = 1'b0;
        ddr3_rd_valid = 1'b0;
        fifo_pop = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            read_done_p = 1'b0;
            ddr3_rd_valid = 1'b0;
            fifo_pop = 1'b0;
            if (!rst_n) begin
                ack_cnt = 0;
                pend = 0;
                fifo_lvl = 0;
            end else begin
                ack_cnt = read_en ? ack_cnt + 1 : 0;
                if (ack_cnt == 3) begin
                    read_done_p = 1'b1;
                    pend += int'(ddr3_axi_len) + 1;
                end
                if (pend > 0) begin
                    ddr3_rd_valid = 1'b1;
                    pend--;
                    fifo_lvl++;
                    valid_total++;
                end
                if ((pop_budget > 0 && fifo_lvl > 0) || (pop_on_ack && read_done_p)) begin
                    fifo_pop = 1'b1;
                    if (fifo_lvl > 0) fifo_lvl--;
                    if (pop_budget > 0) pop_budget--;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (read_en && !re_q) begin
                req_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_req: got addr=%h len=%0d, required no request", ddr3_rd_addr, ddr3_axi_len);
                end else begin
                    req_t e;
                    e = exp_q.pop_front();
                    if (ddr3_rd_addr !== e.addr || ddr3_axi_len !== e.len) begin
                        errors++;
                        $display("FAIL req: got addr=%h len=%0d, required addr=%h len=%0d", ddr3_rd_addr, ddr3_axi_len, e.addr, e.len);
                    end
                end
                hold_addr = ddr3_rd_addr;
                hold_len = ddr3_axi_len;
            end else if (read_en) begin
                checks++;
                if (ddr3_rd_addr !== hold_addr || ddr3_axi_len !== hold_len) begin
                    errors++;
                    $display("FAIL req_stable: got addr=%h len=%0d, required addr=%h len=%0d", ddr3_rd_addr, ddr3_axi_len, hold_addr, hold_len);
                end
            end
            re_q = read_en;
            if (frame_done) begin
                done_cnt++;
                checks++;
                if (valid_total !== exp_beats) begin
                    errors++;
                    $display("FAIL done_beats: got %0d beats returned, required %0d", valid_total, exp_beats);
                end
            end
        end
    end

    task automatic push_frame(input logic [AW-1:0] base, input int beats);
        logic [AW-1:0] a = base;
        int r = beats;
        exp_beats = beats;
        valid_total = 0;
        while (r > 0) begin
            req_t e;
            int b = (r > 16) ? 16 : r;
            e.addr = a;
            e.len = 4'(b - 1);
            exp_q.push_back(e);
            a = a + AW'(b * 8);
            r -= b;
        end
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [CW-1:0] n);
        @(posedge clk);
        #1;
        frame_base = b;
        frame_beats = n;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        pop_budget = 0;
        pop_on_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int limit, input string name);
        int d0 = done_cnt;
        int i = 0;
        while (done_cnt == d0 && i < limit) begin
            @(negedge clk);
            #1;
            i++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s_timeout: got no frame_done in %0d cycles, required one", name, limit);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: got %0d requests outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if ({read_en, busy, frame_done, ddr3_axi_ap} !== 4'b0 || ddr3_rd_addr !== '0 || ddr3_axi_len !== 4'd0 || ddr3_axi_id !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b busy=%b done=%b addr=%h len=%0d id=%0d ap=%b, required all zero",
                     read_en, busy, frame_done, ddr3_rd_addr, ddr3_axi_len, ddr3_axi_id, ddr3_axi_ap);
        end
        checks++;
        if (dut.u_credit.credit !== 21'(DEPTH)) begin
            errors++;
            $display("FAIL reset_credit: got %0d, required %0d", dut.u_credit.credit, DEPTH);
        end
        @(posedge clk);
        #1;
        fifo_pop = 1'b1;
        @(negedge clk);
        fifo_pop = 1'b0;
        @(negedge clk);
        checks++;
        if (dut.u_credit.credit !== 21'(DEPTH)) begin
            errors++;
            $display("FAIL credit_saturate: got %0d, required %0d", dut.u_credit.credit, DEPTH);
        end
    endtask

    task automatic test_frame48();
        apply_reset();
        pop_budget = 100000;
        push_frame(28'h100, 48);
        do_start(28'h100, 20'd48);
        @(negedge clk);
        checks++;
        if (read_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL latency_early: got en=%b busy=%b, required en=0 busy=1", read_en, busy);
        end
        @(negedge clk);
        checks++;
        if (read_en !== 1'b1) begin
            errors++;
            $display("FAIL latency_start: got en=%b, required 1", read_en);
        end
        wait_done(500, "frame48");
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame48_idle: got busy=%b done=%b, required 0 0", busy, frame_done);
        end
    endtask

    task automatic test_short_and_wrap();
        apply_reset();
        pop_budget = 100000;
        push_frame(28'h1000, 20);
        do_start(28'h1000, 20'd20);
        wait_done(300, "short20");
        push_frame(28'hFFFFFC0, 32);
        do_start(28'hFFFFFC0, 20'd32);
        wait_done(300, "wrap");
    endtask

    task automatic test_credit_gate();
        int r0;
        apply_reset();
        r0 = req_cnt;
        push_frame(28'h0, 64);
        do_start(28'h0, 20'd64);
        repeat (60) @(negedge clk);
        checks++;
        if (req_cnt - r0 !== 2 || read_en !== 1'b0) begin
            errors++;
            $display("FAIL credit_stall: got %0d requests en=%b, required 2 requests en=0", req_cnt - r0, read_en);
        end
        checks++;
        if (dut.u_credit.credit !== 21'd0) begin
            errors++;
            $display("FAIL credit_empty: got %0d, required 0", dut.u_credit.credit);
        end
        pop_budget = 16;
        repeat (40) @(negedge clk);
        checks++;
        if (req_cnt - r0 !== 3) begin
            errors++;
            $display("FAIL credit_resume: got %0d requests, required 3", req_cnt - r0);
        end
        pop_budget = 100000;
        wait_done(500, "credit64");
        repeat (40) @(negedge clk);
        checks++;
        if (dut.u_credit.credit !== 21'(DEPTH)) begin
            errors++;
            $display("FAIL credit_refill: got %0d, required %0d", dut.u_credit.credit, DEPTH);
        end
    endtask

    task automatic test_simultaneous();
        int i = 0;
        apply_reset();
        pop_on_ack = 1'b1;
        push_frame(28'h400, 16);
        do_start(28'h400, 20'd16);
        while (read_done_p !== 1'b1 && i < 50) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        checks++;
        if (dut.u_credit.credit !== 21'd17) begin
            errors++;
            $display("FAIL credit_simul: got %0d, required 17", dut.u_credit.credit);
        end
        pop_on_ack = 1'b0;
        pop_budget = 100000;
        wait_done(300, "simul");
    endtask

    task automatic test_zero_and_ignore();
        int r0;
        apply_reset();
        pop_budget = 100000;
        r0 = req_cnt;
        push_frame(28'h800, 0);
        do_start(28'h800, 20'd0);
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_early: got done=%b busy=%b, required 0 1", frame_done, busy);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: got %b, required 1", frame_done);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || req_cnt !== r0) begin
            errors++;
            $display("FAIL zero_after: got done=%b busy=%b reqs=%0d, required 0 0 0", frame_done, busy, req_cnt - r0);
        end
        push_frame(28'h2000, 16);
        do_start(28'h2000, 20'd16);
        repeat (3) @(posedge clk);
        do_start(28'h3000, 20'd16);
        wait_done(300, "ignore");
        repeat (40) @(negedge clk);
        checks++;
        if (req_cnt - r0 !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start: got %0d requests busy=%b, required 1 busy=0", req_cnt - r0, busy);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        int i = 0;
        apply_reset();
        pop_budget = 100000;
        push_frame(28'h500, 32);
        do_start(28'h500, 20'd32);
        while (read_en !== 1'b1 && i < 50) begin
            @(negedge clk);
            i++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (read_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got en=%b busy=%b, required 0 0", read_en, busy);
        end
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (done_cnt !== d0 || read_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_abandon: got %0d frame_done en=%b, required 0 en=0", done_cnt - d0, read_en);
        end
    endtask

    initial begin
        test_reset();
        test_frame48();
        test_short_and_wrap();
        test_credit_gate();
        test_simultaneous();
        test_zero_and_ignore();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
